// File: rtl/stl_lane_pack.sv
// Lane packer: gathers variable-width beats of lanes into full DIM_N-lane words,
// flushing a short final word (and any overflow residual) at packet end.
module stl_lane_pack #(
    parameter int DIM_N = 16,
    parameter int DAT_W = 10,
    parameter int SHT_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic [DIM_N-1:0][DAT_W-1:0]    in_dat,
    input  logic [SHT_W:0]                 in_cnt,
    input  logic                           in_last,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [DIM_N-1:0][DAT_W-1:0]    out_dat,
    output logic [SHT_W:0]                 out_cnt,
    output logic                           out_last
);

    typedef enum logic {
        ACCUM,
        FLUSH
    } state_t;

    localparam logic [SHT_W:0]   CNT_MAX  = (SHT_W+1)'(DIM_N);
    localparam logic [SHT_W+1:0] TOT_FULL = (SHT_W+2)'(DIM_N);

    state_t                        state_q,   state_d;
    logic [DIM_N-1:0][DAT_W-1:0]   acc_q,     acc_d;
    logic [SHT_W-1:0]              fill_q,    fill_d;
    logic                          outVld_q,  outVld_d;
    logic [DIM_N-1:0][DAT_W-1:0]   outDat_q,  outDat_d;
    logic [SHT_W:0]                outCnt_q,  outCnt_d;
    logic                          outLast_q, outLast_d;

    logic [SHT_W:0]                inCntClamp;
    logic [SHT_W+1:0]              total;
    logic [DIM_N-1:0][DAT_W-1:0]   rot;
    logic [DIM_N-1:0][DAT_W-1:0]   merged;
    logic [DIM_N-1:0][DAT_W-1:0]   mergedMasked;
    logic [DIM_N-1:0][DAT_W-1:0]   residual;
    logic [DIM_N-1:0][DAT_W-1:0]   flushWord;
    logic                          outFree;
    logic                          accept;

    assign outFree = !outVld_q || out_rdy;
    assign in_rdy  = (state_q == ACCUM) && outFree;
    assign accept  = in_vld && in_rdy;

    // Rotate the incoming lanes up by the fill level and splice them behind the
    // accumulated lanes; also precompute every masked word shape we may emit.
    always_comb begin
        inCntClamp = (in_cnt > CNT_MAX) ? CNT_MAX : in_cnt;
        total      = (SHT_W+2)'(fill_q) + (SHT_W+2)'(inCntClamp);
        for (int k = 0; k < DIM_N; k++) begin
            rot[k]          = in_dat[SHT_W'(k - int'(fill_q))];
            merged[k]       = (k < int'(fill_q)) ? acc_q[k] : rot[k];
            mergedMasked[k] = (k < int'(total)) ? merged[k] : '0;
            residual[k]     = (k < int'(total) - DIM_N) ? rot[k] : '0;
            flushWord[k]    = (k < int'(fill_q)) ? acc_q[k] : '0;
        end
    end

    // Next-state: accumulate, emit full words, or close the packet; an emitted
    // word always takes the output register, otherwise a taken word frees it.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        outVld_d  = outVld_q && !out_rdy;
        outDat_d  = outDat_q;
        outCnt_d  = outCnt_q;
        outLast_d = outLast_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (in_last && total <= TOT_FULL) begin
                        outVld_d  = 1'b1;
                        outDat_d  = mergedMasked;
                        outCnt_d  = total[SHT_W:0];
                        outLast_d = 1'b1;
                        acc_d     = '0;
                        fill_d    = '0;
                    end else if (total >= TOT_FULL) begin
                        outVld_d  = 1'b1;
                        outDat_d  = merged;
                        outCnt_d  = CNT_MAX;
                        outLast_d = 1'b0;
                        acc_d     = residual;
                        fill_d    = SHT_W'(total - TOT_FULL);
                        if (in_last) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        acc_d  = mergedMasked;
                        fill_d = total[SHT_W-1:0];
                    end
                end
            end
            FLUSH: begin
                if (outFree) begin
                    outVld_d  = 1'b1;
                    outDat_d  = flushWord;
                    outCnt_d  = (SHT_W+1)'(fill_q);
                    outLast_d = 1'b1;
                    acc_d     = '0;
                    fill_d    = '0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            fill_q    <= '0;
            outVld_q  <= 1'b0;
            outDat_q  <= '0;
            outCnt_q  <= '0;
            outLast_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            outVld_q  <= outVld_d;
            outDat_q  <= outDat_d;
            outCnt_q  <= outCnt_d;
            outLast_q <= outLast_d;
        end
    end

    assign out_vld  = outVld_q;
    assign out_dat  = outDat_q;
    assign out_cnt  = outCnt_q;
    assign out_last = outLast_q;

endmodule

// File: tb/tb_stl_lane_pack.sv
// Directed bench for stl_lane_pack: packing, overflow split, flush,
// backpressure, reset abandonment and empty last beats.
module tb_stl_lane_pack;

    localparam int DIM_N = 16;
    localparam int DAT_W = 10;
    localparam int SHT_W = 4;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         in_vld = 1'b0;
    logic                         in_rdy;
    logic [DIM_N-1:0][DAT_W-1:0]  in_dat = '0;
    logic [SHT_W:0]               in_cnt = '0;
    logic                         in_last = 1'b0;
    logic                         out_vld;
    logic                         out_rdy = 1'b1;
    logic [DIM_N-1:0][DAT_W-1:0]  out_dat;
    logic [SHT_W:0]               out_cnt;
    logic                         out_last;

    int checks = 0;
    int failures = 0;

    stl_lane_pack #(.DIM_N(DIM_N), .DAT_W(DAT_W), .SHT_W(SHT_W)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_cnt(in_cnt), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_cnt(out_cnt), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DIM_N-1:0][DAT_W-1:0] laneSeq(input int base, input int n);
        logic [DIM_N-1:0][DAT_W-1:0] v;
        v = '0;
        for (int k = 0; k < DIM_N; k++)
            if (k < n) v[k] = DAT_W'(base + k);
        return v;
    endfunction

    // Present one beat at the falling edge, wait (bounded) for in_rdy, and
    // return just after the accepting rising edge with in_vld dropped.
    task automatic sendBeat(input int cnt, input bit last, input int base);
        int guard;
        logic [DIM_N-1:0][DAT_W-1:0] d;
        guard = 0;
        for (int j = 0; j < DIM_N; j++)
            d[j] = (j < cnt) ? DAT_W'(base + j) : 10'h3AA;
        @(negedge clk);
        in_vld  = 1'b1;
        in_cnt  = (SHT_W+1)'(cnt);
        in_last = last;
        in_dat  = d;
        while (!in_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_accept_timeout actual=in_rdy=0 required=in_rdy=1");
        end
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0 || out_cnt !== '0 || out_last !== 1'b0 || out_dat !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual=vld%0b cnt%0d last%0b dat%h required=all zero", out_vld, out_cnt, out_last, out_dat);
        end
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_rdy actual=%0b required=1", in_rdy);
        end
    endtask

    task automatic test_four_beats;
        sendBeat(4, 1'b0, 0);
        sendBeat(4, 1'b0, 4);
        sendBeat(4, 1'b0, 8);
        checks++;
        if (out_vld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL four_beats_early_vld actual=%0b required=0", out_vld);
        end
        sendBeat(4, 1'b0, 12);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd16 || out_last !== 1'b0 || out_dat !== laneSeq(0, 16)) begin
            failures++;
            $display("[TB] FAIL four_beats_word actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt16 last0 dat%h",
                     out_vld, out_cnt, out_last, out_dat, laneSeq(0, 16));
        end
        idle(1);
        checks++;
        if (out_vld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL four_beats_drain actual=%0b required=0", out_vld);
        end
    endtask

    task automatic test_split;
        logic [DIM_N-1:0][DAT_W-1:0] e;
        sendBeat(12, 1'b0, 100);
        sendBeat(8, 1'b0, 200);
        e = laneSeq(100, 12);
        for (int k = 12; k < 16; k++) e[k] = DAT_W'(200 + k - 12);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd16 || out_last !== 1'b0 || out_dat !== e) begin
            failures++;
            $display("[TB] FAIL split_word actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt16 last0 dat%h",
                     out_vld, out_cnt, out_last, out_dat, e);
        end
        sendBeat(0, 1'b1, 0);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd4 || out_last !== 1'b1 || out_dat !== laneSeq(204, 4)) begin
            failures++;
            $display("[TB] FAIL split_residual actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt4 last1 dat%h",
                     out_vld, out_cnt, out_last, out_dat, laneSeq(204, 4));
        end
        idle(1);
    endtask

    task automatic test_last_flush;
        logic [DIM_N-1:0][DAT_W-1:0] e;
        sendBeat(12, 1'b0, 300);
        sendBeat(8, 1'b1, 400);
        e = laneSeq(300, 12);
        for (int k = 12; k < 16; k++) e[k] = DAT_W'(400 + k - 12);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd16 || out_last !== 1'b0 || out_dat !== e) begin
            failures++;
            $display("[TB] FAIL flush_full_word actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt16 last0 dat%h",
                     out_vld, out_cnt, out_last, out_dat, e);
        end
        checks++;
        if (in_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_in_rdy actual=%0b required=0", in_rdy);
        end
        idle(1);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd4 || out_last !== 1'b1 || out_dat !== laneSeq(404, 4)) begin
            failures++;
            $display("[TB] FAIL flush_residual actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt4 last1 dat%h",
                     out_vld, out_cnt, out_last, out_dat, laneSeq(404, 4));
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_return_rdy actual=%0b required=1", in_rdy);
        end
        idle(1);
    endtask

    task automatic test_backpressure;
        int stalls;
        out_rdy = 1'b0;
        sendBeat(16, 1'b0, 500);
        @(negedge clk);
        in_vld  = 1'b1;
        in_cnt  = 5'd16;
        in_dat  = laneSeq(600, 16);
        stalls  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_rdy !== 1'b0 || out_vld !== 1'b1 || out_cnt !== 5'd16 || out_dat !== laneSeq(500, 16)) stalls++;
        end
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("[TB] FAIL backpressure_hold actual=%0d bad cycles required=0", stalls);
        end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_release_rdy actual=%0b required=1", in_rdy);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b1 || out_dat !== laneSeq(600, 16) || out_cnt !== 5'd16) begin
            failures++;
            $display("[TB] FAIL backpressure_next_word actual=vld%0b cnt%0d dat%h required=vld1 cnt16 dat%h",
                     out_vld, out_cnt, out_dat, laneSeq(600, 16));
        end
        idle(1);
        checks++;
        if (out_vld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_drain actual=%0b required=0", out_vld);
        end
    endtask

    task automatic test_reset_flush;
        out_rdy = 1'b0;
        sendBeat(12, 1'b0, 700);
        sendBeat(8, 1'b1, 720);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0 || out_cnt !== '0 || out_last !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_flush actual=vld%0b cnt%0d last%0b required=vld0 cnt0 last0", out_vld, out_cnt, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_flush_rdy actual=%0b required=1", in_rdy);
        end
        sendBeat(3, 1'b1, 800);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd3 || out_last !== 1'b1 || out_dat !== laneSeq(800, 3)) begin
            failures++;
            $display("[TB] FAIL reset_flush_repack actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt3 last1 dat%h",
                     out_vld, out_cnt, out_last, out_dat, laneSeq(800, 3));
        end
        idle(1);
    endtask

    task automatic test_empty_last;
        sendBeat(0, 1'b1, 0);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd0 || out_last !== 1'b1 || out_dat !== '0) begin
            failures++;
            $display("[TB] FAIL empty_last actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt0 last1 dat0",
                     out_vld, out_cnt, out_last, out_dat);
        end
        idle(1);
    endtask

    task automatic test_clamp;
        sendBeat(20, 1'b0, 900);
        checks++;
        if (out_vld !== 1'b1 || out_cnt !== 5'd16 || out_last !== 1'b0 || out_dat !== laneSeq(900, 16)) begin
            failures++;
            $display("[TB] FAIL clamp_word actual=vld%0b cnt%0d last%0b dat%h required=vld1 cnt16 last0 dat%h",
                     out_vld, out_cnt, out_last, out_dat, laneSeq(900, 16));
        end
        sendBeat(0, 1'b1, 0);
        checks++;
        if (out_cnt !== 5'd0 || out_last !== 1'b1 || out_vld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clamp_no_residual actual=cnt%0d last%0b required=cnt0 last1", out_cnt, out_last);
        end
        idle(1);
    endtask

    initial begin
        test_reset;
        test_four_beats;
        test_split;
        test_last_flush;
        test_backpressure;
        test_reset_flush;
        test_empty_last;
        test_clamp;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
